// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port between the ROM download writer
// (port 0), CPU ROM fetch (port 1) and tile fetch (port 2); one transaction in flight.
module sdram_arbiter #(
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load_active,
    input  logic [2:0]            req,
    input  logic [2:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [ADDR_WIDTH-1:0] addr2,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [2:0]            ack,
    output logic [2:0]            valid,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  ctrl_req,
    output logic                  ctrl_we,
    output logic [ADDR_WIDTH-1:0] ctrl_addr,
    output logic [DATA_WIDTH-1:0] ctrl_din,
    input  logic                  ctrl_ack,
    input  logic                  ctrl_valid,
    input  logic [DATA_WIDTH-1:0] ctrl_dout
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t                state_q, state_d;
    logic [1:0]            last_q, last_d;
    logic [1:0]            gnt_q, gnt_d;
    logic                  ctrl_req_q, ctrl_req_d;
    logic                  ctrl_we_q, ctrl_we_d;
    logic [ADDR_WIDTH-1:0] ctrl_addr_q, ctrl_addr_d;
    logic [DATA_WIDTH-1:0] ctrl_din_q, ctrl_din_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [2:0]            ack_q, ack_d;
    logic [2:0]            valid_q, valid_d;

    logic [2:0]            eligible;
    logic [1:0]            cand1, cand2, pick;

    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // A port whose ack is showing this cycle still has its stale req up; skip it.
    assign eligible = req & {~load_active, ~load_active, 1'b1} & ~ack_q;
    assign cand1    = rr_next(last_q);
    assign cand2    = rr_next(cand1);
    assign pick     = eligible[cand1] ? cand1 : (eligible[cand2] ? cand2 : last_q);

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        ctrl_req_d  = ctrl_req_q;
        ctrl_we_d   = ctrl_we_q;
        ctrl_addr_d = ctrl_addr_q;
        ctrl_din_d  = ctrl_din_q;
        dout_d      = dout_q;
        ack_d       = 3'b000;
        valid_d     = 3'b000;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    gnt_d      = pick;
                    last_d     = pick;
                    ctrl_req_d = 1'b1;
                    ctrl_we_d  = (pick == 2'd0) && we[0];
                    ctrl_din_d = din0;
                    case (pick)
                        2'd1:    ctrl_addr_d = addr1;
                        2'd2:    ctrl_addr_d = addr2;
                        default: ctrl_addr_d = addr0;
                    endcase
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ctrl_ack) begin
                    ctrl_req_d = 1'b0;
                    ack_d      = 3'b001 << gnt_q;
                    if (ctrl_we_q) begin
                        state_d = IDLE;
                    end else if (ctrl_valid) begin
                        // Zero-latency read: data arrives with the accept.
                        dout_d  = ctrl_dout;
                        valid_d = 3'b001 << gnt_q;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (ctrl_valid) begin
                    dout_d  = ctrl_dout;
                    valid_d = 3'b001 << gnt_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            last_q      <= 2'd2;
            gnt_q       <= 2'd0;
            ctrl_req_q  <= 1'b0;
            ctrl_we_q   <= 1'b0;
            ctrl_addr_q <= '0;
            ctrl_din_q  <= '0;
            dout_q      <= '0;
            ack_q       <= 3'b000;
            valid_q     <= 3'b000;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            ctrl_req_q  <= ctrl_req_d;
            ctrl_we_q   <= ctrl_we_d;
            ctrl_addr_q <= ctrl_addr_d;
            ctrl_din_q  <= ctrl_din_d;
            dout_q      <= dout_d;
            ack_q       <= ack_d;
            valid_q     <= valid_d;
        end
    end

    assign ack       = ack_q;
    assign valid     = valid_q;
    assign dout      = dout_q;
    assign ctrl_req  = ctrl_req_q;
    assign ctrl_we   = ctrl_we_q;
    assign ctrl_addr = ctrl_addr_q;
    assign ctrl_din  = ctrl_din_q;
endmodule
